frame_sync_ctrl: RTL and testbench

- Frame-synchronisation controller that sequences header detection on the byte stream.
- Takes per-byte header-hit pulses from the header detector alongside the same `din` bytes, and runs a hunt/verify/lock/flywheel state machine.
- Once locked, emits the fixed-length payload of each frame with start/end markers and counts frames.
- Sits directly after the header detector and ahead of the payload consumers.

---
 rtl/frame_sync_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: hunt/verify/lock/flywheel frame synchroniser.
// Consumes stream bytes plus per-byte header-hit pulses from the header
// detector. Once locked, it forwards the fixed-length payload of each frame
// with start/end markers and counts delivered frames.
// Optional build macro FRAME_SYNC_STATS_EN adds lol_cnt, a saturating count
// of lock-loss events.
// Handshake: din is consumed in every cycle where din_vld=1; there is no
// back-pressure. pld_data is meaningful only in cycles where pld_vld=1.
module frame_sync_ctrl #(
   parameter int FRAME_LEN = 8,
   parameter int HDR_LEN   = 2,
   parameter int LOCK_CNT  = 3,
   parameter int MISS_CNT  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  din,
   input  logic        din_vld,
   input  logic        hdr_hit,
   output logic [1:0]  state,
   output logic        lock,
   output logic        pld_vld,
   output logic [7:0]  pld_data,
   output logic        pld_sof,
   output logic        pld_eof,
   output logic        err_miss,
   output logic [15:0] frame_cnt
`ifdef FRAME_SYNC_STATS_EN
   ,
   output logic [7:0]  lol_cnt
`endif
);

   localparam int PERIOD = FRAME_LEN + HDR_LEN;
   localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int GW     = $clog2(LOCK_CNT + 1);
   localparam int MW     = $clog2(MISS_CNT + 1);

   localparam logic [PW-1:0] CHK_IDX  = PW'(PERIOD - 1);
   localparam logic [PW-1:0] LAST_PLD = PW'(FRAME_LEN - 1);
   localparam logic [PW-1:0] PLD_END  = PW'(FRAME_LEN);
   localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);
   localparam logic [MW-1:0] MISS_V   = MW'(MISS_CNT);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2,
      ST_FLY    = 2'd3
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_pos;
   logic [GW-1:0] r_good;
   logic [MW-1:0] r_miss;
   logic          r_lock;
   logic          r_pld_vld;
   logic [7:0]    r_pld_data;
   logic          r_pld_sof;
   logic          r_pld_eof;
   logic          r_err_miss;
   logic [15:0]   r_frame_cnt;

   state_t        w_state_nxt;
   logic [PW-1:0] w_pos_nxt;
   logic [GW-1:0] w_good_nxt;
   logic [MW-1:0] w_miss_nxt;
   logic          w_err;
   logic          w_fwd;
   logic          w_chk;
   logic          w_locked;
   logic [GW-1:0] w_good_inc;
   logic [MW-1:0] w_miss_inc;

   assign w_chk      = (r_pos == CHK_IDX);
   assign w_locked   = (r_state == ST_LOCK) || (r_state == ST_FLY);
   assign w_good_inc = r_good + GW'(1);
   assign w_miss_inc = r_miss + MW'(1);

   // Next-state, byte position, header counters and forward decision per valid byte.
   always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      w_good_nxt  = r_good;
      w_miss_nxt  = r_miss;
      w_err       = 1'b0;
      w_fwd       = 1'b0;
      if (din_vld) begin
         // Payload is forwarded based on the state before this byte, so a
         // lock gained on a header byte starts delivery at the next frame.
         w_fwd     = w_locked && (r_pos < PLD_END);
         // The check byte always wraps the position: phase is preserved
         // regardless of whether the header was seen.
         w_pos_nxt = w_chk ? '0 : r_pos + PW'(1);
         case (r_state)
            ST_HUNT: begin
               w_pos_nxt = '0;
               if (hdr_hit) begin
                  w_good_nxt  = GW'(1);
                  w_state_nxt = (LOCK_CNT <= 1) ? ST_LOCK : ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (w_chk) begin
                  if (hdr_hit) begin
                     w_good_nxt = w_good_inc;
                     if (w_good_inc >= LOCK_V) w_state_nxt = ST_LOCK;
                  end else begin
                     w_state_nxt = ST_HUNT;
                  end
               end else if (hdr_hit) begin
                  // Off-phase header: adopt the new phase and restart counting.
                  w_good_nxt = GW'(1);
                  w_pos_nxt  = '0;
               end
            end
            ST_LOCK: begin
               if (w_chk && !hdr_hit) begin
                  w_err       = 1'b1;
                  w_miss_nxt  = MW'(1);
                  w_state_nxt = (MISS_CNT <= 1) ? ST_HUNT : ST_FLY;
               end
            end
            default: begin
               if (w_chk) begin
                  if (hdr_hit) begin
                     w_state_nxt = ST_LOCK;
                     w_miss_nxt  = '0;
                  end else begin
                     w_err      = 1'b1;
                     w_miss_nxt = w_miss_inc;
                     if (w_miss_inc >= MISS_V) w_state_nxt = ST_HUNT;
                  end
               end
            end
         endcase
      end
   end

   // FSM state and position/good/miss counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HUNT;
         r_pos   <= '0;
         r_good  <= '0;
         r_miss  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pos   <= w_pos_nxt;
         r_good  <= w_good_nxt;
         r_miss  <= w_miss_nxt;
      end
   end

   // Registered outputs: lock flag, payload stream, miss pulse and frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock      <= 1'b0;
         r_pld_vld   <= 1'b0;
         r_pld_data  <= '0;
         r_pld_sof   <= 1'b0;
         r_pld_eof   <= 1'b0;
         r_err_miss  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_lock     <= (w_state_nxt == ST_LOCK) || (w_state_nxt == ST_FLY);
         r_pld_vld  <= w_fwd;
         r_pld_sof  <= w_fwd && (r_pos == '0);
         r_pld_eof  <= w_fwd && (r_pos == LAST_PLD);
         r_err_miss <= w_err;
         if (w_fwd) r_pld_data <= din;
         if (w_fwd && (r_pos == LAST_PLD)) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

`ifdef FRAME_SYNC_STATS_EN
   logic [7:0] r_lol_cnt;
   logic       w_lol;

   assign w_lol = din_vld && w_locked && (w_state_nxt == ST_HUNT);

   // Saturating count of lock-loss events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lol_cnt <= '0;
      end else if (w_lol && (r_lol_cnt != 8'hFF)) begin
         r_lol_cnt <= r_lol_cnt + 8'd1;
      end
   end

   assign lol_cnt = r_lol_cnt;
`endif

   assign state     = r_state;
   assign lock      = r_lock;
   assign pld_vld   = r_pld_vld;
   assign pld_data  = r_pld_data;
   assign pld_sof   = r_pld_sof;
   assign pld_eof   = r_pld_eof;
   assign err_miss  = r_err_miss;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Testbench for frame_sync_ctrl: directed scenarios plus randomized frame
// traffic, every cycle compared against a behavioural model that tracks
// frame phase arithmetically from the byte number of the accepted header.
module tb_frame_sync_ctrl;

   localparam int FRAME_LEN = 8;
   localparam int HDR_LEN   = 2;
   localparam int LOCK_CNT  = 3;
   localparam int MISS_CNT  = 2;
   localparam int PERIOD    = FRAME_LEN + HDR_LEN;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  din;
   logic        din_vld;
   logic        hdr_hit;
   logic [1:0]  state;
   logic        lock;
   logic        pld_vld;
   logic [7:0]  pld_data;
   logic        pld_sof;
   logic        pld_eof;
   logic        err_miss;
   logic [15:0] frame_cnt;
`ifdef FRAME_SYNC_STATS_EN
   logic [7:0]  lol_cnt;
`endif

   always #5 clk = ~clk;

   frame_sync_ctrl #(
      .FRAME_LEN(FRAME_LEN),
      .HDR_LEN  (HDR_LEN),
      .LOCK_CNT (LOCK_CNT),
      .MISS_CNT (MISS_CNT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_vld  (din_vld),
      .hdr_hit  (hdr_hit),
      .state    (state),
      .lock     (lock),
      .pld_vld  (pld_vld),
      .pld_data (pld_data),
      .pld_sof  (pld_sof),
      .pld_eof  (pld_eof),
      .err_miss (err_miss),
      .frame_cnt(frame_cnt)
`ifdef FRAME_SYNC_STATS_EN
      ,
      .lol_cnt  (lol_cnt)
`endif
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Modes: 0 hunt, 1 verify, 2 lock, 3 flywheel. Frame index of a byte is
   // derived from its distance to the last accepted header byte.
   int         m_mode;
   int         m_cur;
   int         m_anchor;
   int         m_good;
   int         m_miss;
   int         m_fcnt;
   int         m_lol;
   logic       e_vld;
   logic [7:0] e_data;
   logic       e_sof;
   logic       e_eof;
   logic       e_err;

   task automatic model_reset();
      m_mode = 0; m_cur = 0; m_anchor = -1; m_good = 0; m_miss = 0;
      m_fcnt = 0; m_lol = 0;
      e_vld = 0; e_data = 0; e_sof = 0; e_eof = 0; e_err = 0;
   endtask

   task automatic lose_lock();
      m_mode = 0;
      if (m_lol < 255) m_lol++;
   endtask

   task automatic model_step(input logic [7:0] d, input bit h, input bit v);
      int  idx;
      bit  chk;
      e_vld = 0;
      e_err = 0;
      if (v) begin
         idx = (m_cur - m_anchor - 1) % PERIOD;
         chk = (idx == PERIOD - 1);
         if (m_mode >= 2 && idx < FRAME_LEN) begin
            e_vld  = 1;
            e_data = d;
            e_sof  = (idx == 0);
            e_eof  = (idx == FRAME_LEN - 1);
            if (e_eof) m_fcnt = (m_fcnt + 1) & 16'hFFFF;
         end
         if (m_mode == 0) begin
            if (h) begin
               m_anchor = m_cur;
               m_good   = 1;
               m_mode   = (m_good >= LOCK_CNT) ? 2 : 1;
            end
         end else if (m_mode == 1) begin
            if (chk) begin
               if (h) begin
                  m_good++;
                  if (m_good >= LOCK_CNT) m_mode = 2;
               end else begin
                  m_mode = 0;
               end
            end else if (h) begin
               m_anchor = m_cur;
               m_good   = 1;
            end
         end else if (m_mode == 2) begin
            if (chk && !h) begin
               e_err  = 1;
               m_miss = 1;
               if (m_miss >= MISS_CNT) lose_lock();
               else m_mode = 3;
            end
         end else begin
            if (chk) begin
               if (h) begin
                  m_mode = 2;
                  m_miss = 0;
               end else begin
                  e_err = 1;
                  m_miss++;
                  if (m_miss >= MISS_CNT) lose_lock();
               end
            end
         end
         m_cur++;
      end
   endtask

   task automatic compare_all();
      check("state", 32'(state), 32'(m_mode));
      check("lock", 32'(lock), 32'(m_mode >= 2));
      check("pld_vld", 32'(pld_vld), 32'(e_vld));
      if (e_vld) begin
         check("pld_data", 32'(pld_data), 32'(e_data));
         check("pld_sof", 32'(pld_sof), 32'(e_sof));
         check("pld_eof", 32'(pld_eof), 32'(e_eof));
      end
      check("err_miss", 32'(err_miss), 32'(e_err));
      check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`ifdef FRAME_SYNC_STATS_EN
      check("lol_cnt", 32'(lol_cnt), 32'(m_lol));
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic [7:0] d, input bit h, input bit v);
      din     = d;
      din_vld = v;
      hdr_hit = h;
      model_step(d, h, v);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input logic [7:0] d, input bit h);
      cycle(d, h, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(8'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic header(input bit good);
      send(good ? 8'h55 : 8'h56, 1'b0);
      send(good ? 8'hD5 : 8'hD6, good);
   endtask

   task automatic payload(input bit ramp, input int gap_at, input int gap_len, input int spur_at);
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i == gap_at) idle(gap_len);
         send(ramp ? 8'(i) : 8'($urandom_range(0, 255)), i == spur_at);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("rst_data", 32'(pld_data), 32'd0);
      check("rst_sof", 32'(pld_sof), 32'd0);
      check("rst_eof", 32'(pld_eof), 32'd0);
      for (int i = 0; i < 4; i++) begin
         din     = 8'($urandom);
         din_vld = 1'($urandom);
         hdr_hit = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         compare_all();
      end
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n   = 1'b0;
      din     = '0;
      din_vld = 1'b0;
      hdr_hit = 1'b0;
      @(negedge clk);
      do_reset();

      // Acquire: three aligned headers, then a ramp payload.
      header(1); payload(0, -1, 0, -1);
      header(1); payload(0, -1, 0, -1);
      header(1);
      check("acq_lock", 32'(lock), 32'd1);
      payload(1, -1, 0, -1);
      check("acq_fcnt", 32'(frame_cnt), 32'd1);

      // Single miss then recovery.
      header(0);
      check("miss_pulse", 32'(err_miss), 32'd1);
      check("miss_state", 32'(state), 32'd3);
      check("miss_lock", 32'(lock), 32'd1);
      payload(0, -1, 0, -1);
      header(1);
      check("relock_state", 32'(state), 32'd2);
      payload(0, -1, 0, -1);

      // Lock loss: two consecutive bad headers.
      header(0); payload(0, -1, 0, -1);
      header(0);
      check("loss_state", 32'(state), 32'd0);
      check("loss_lock", 32'(lock), 32'd0);
`ifdef FRAME_SYNC_STATS_EN
      check("loss_lol", 32'(lol_cnt), 32'd1);
`endif

      // Resync in verify after two good hits.
      do_reset();
      header(1); payload(0, -1, 0, -1);
      header(1);
      for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
      send(8'hD5, 1'b1);
      check("resync_state", 32'(state), 32'd1);
      payload(0, -1, 0, -1); header(1);
      check("resync_verify", 32'(state), 32'd1);
      payload(0, -1, 0, -1); header(1);
      check("resync_lock", 32'(state), 32'd2);

      // Gap of three idle cycles mid-payload while locked.
      payload(0, 3, 3, -1);
      header(1);
      check("gap_fcnt", 32'(frame_cnt), 32'd1);
      payload(1, 5, 3, -1);
      check("gap_fcnt2", 32'(frame_cnt), 32'd2);

      // Randomized traffic: bad headers, spurious hits, gaps, slips, resets.
      for (int f = 0; f < 200; f++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         header($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 19) == 0) send(8'($urandom), 1'b0);
         payload(0,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1,
                 int'($urandom_range(1, 3)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1);
      end

      // Reset in the middle of a locked frame.
      header(1); payload(0, -1, 0, -1);
      header(1); payload(0, -1, 0, -1);
      header(1); payload(0, -1, 0, -1);
      header(1);
      for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
      do_reset();
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
